instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Producer-side counterpart of the control decoder: takes symbolic instruction requests and encodes them into 32-bit MIPS words.
- Writes the words sequentially into instruction memory, so test programs and boot images are built in hardware rather than hand-assembled hex.
- Sits between a host/testbench request source and the instruction-memory write port.
- Supports ADD, ADDU, SUB, SUBU, ORI, LW, SW and LUI; J is optional.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after start.
- MAX_WORDS, 1024, maximum words per load session (1..2^ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_op  in  4  0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 ORI, 5 LW, 6 SW, 7 LUI, 8 J (feature only).
- req_rs  in  5  rs field.
- req_rt  in  5  rt field.
- req_rd  in  5  rd field.
- req_imm  in  16  immediate field.
- req_target  in  26  jump target; ignored unless feature enabled.
- req_last  in  1  marks final request of the session.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded instruction.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- err  out  1  sticky unsupported-op flag; cleared by start or rst.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; next address = BASE_ADDR; any in-flight write is dropped.
- FSM states and transitions:
  - IDLE → LOAD on start. On entry to LOAD: count=0, err=0, next address=BASE_ADDR.
  - LOAD → DRAIN when a request with req_last is accepted, or when the accepted request brings written+pending words to MAX_WORDS.
  - DRAIN → DONE after the pending write completes; goes directly to DONE if nothing is pending.
  - DONE → IDLE after one cycle; done=1 for exactly that cycle.
  - start is ignored outside IDLE.
- req_ready=1 only in LOAD, and 0 in the cycle a terminating request is accepted. Field inputs are sampled only on handshake.
- Pipeline:
  - An accepted request is encoded into an output register.
  - im_we=1 on the next cycle with im_addr and im_wdata valid for exactly one cycle.
  - Latency from handshake to write is 1 cycle.
  - Throughput is one word per cycle for back-to-back requests.
- After each write, address increments by 1 modulo 2^ADDR_W (wraps, no error) and count increments.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, 5'h00, funct}; funct ADD 6'h20, ADDU 6'h21, SUB 6'h22, SUBU 6'h23.
  - ORI: {6'h0D, rs, rt, imm}.
  - LW: {6'h23, rs, rt, imm}.
  - SW: {6'h2B, rs, rt, imm}.
  - LUI: {6'h0F, 5'h00, rt, imm}; rs is ignored.
- Unsupported req_op:
  - The request is consumed; no write, no address or count change; err set.
  - If it carries req_last, the session still ends normally.
- busy=1 in LOAD and DRAIN.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro ENCODER_JUMP_EN.
- Defined: req_op 8 encodes J as {6'h02, req_target}.
- Undefined: req_op 8 is treated as unsupported (sets err, no write); req_target is unused.

Test Plan:
- start, then ADD rs=1 rt=2 rd=3 with last → im_we one cycle later, im_addr=0, im_wdata=32'h00221820; done pulses; count=1.
- Back-to-back ORI rs=0 rt=4 imm=16'h00FF, LW rs=4 rt=5 imm=16'h0004, SW rs=4 rt=5 imm=16'h0008 (last) → consecutive writes at addr 0,1,2 of 32'h340400FF, 32'h8C850004, 32'hAC850008; count=3.
- LUI rt=7 imm=16'h1234, rs=31 → 32'h3C071234; the rs field is zeroed.
- req_op=9 mid-session, then SUBU rs=1 rt=2 rd=3 last → no write for op 9; err=1; next write 32'h00221823 at addr 0; err cleared on next start.
- MAX_WORDS=4, BASE_ADDR=1022, ADDR_W=10, 6 requests offered → writes at 1022, 1023, 0, 1; req_ready drops after the 4th accept; done pulses; count=4.
- Assert rst the cycle after a handshake → no im_we; all outputs 0; a new start resumes at BASE_ADDR. With ENCODER_JUMP_EN, J target=26'h0000100 → 32'h08000100; without it, err=1.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instruction requests and streams them into instruction memory.
// Optional J support is compiled in with `define ENCODER_JUMP_EN.
module instr_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_target,
   input  logic              req_last,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   // Request handshake: a request transfers at a rising edge where req_valid && req_ready.
   // req_ready is high only while loading and falls at the edge that accepts the final request.
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   MAXW = (ADDR_W + 1)'(MAX_WORDS);

   state_t            state;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W:0]   issued;
   logic [31:0]       enc_word;
   logic              enc_ok;
   logic              accept;
   logic              term;

   always_comb begin
      enc_word = '0;
      enc_ok   = 1'b1;
      case (req_op)
         4'd0: enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h20};
         4'd1: enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h21};
         4'd2: enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h22};
         4'd3: enc_word = {6'h00, req_rs, req_rt, req_rd, 5'h00, 6'h23};
         4'd4: enc_word = {6'h0D, req_rs, req_rt, req_imm};
         4'd5: enc_word = {6'h23, req_rs, req_rt, req_imm};
         4'd6: enc_word = {6'h2B, req_rs, req_rt, req_imm};
         4'd7: enc_word = {6'h0F, 5'h00, req_rt, req_imm};
`ifdef ENCODER_JUMP_EN
         4'd8: enc_word = {6'h02, req_target};
`endif
         default: enc_ok = 1'b0;
      endcase
   end

`ifndef ENCODER_JUMP_EN
   logic unused_target;
   assign unused_target = ^req_target;
`endif

   assign accept = req_valid && req_ready;
   // issued counts words written plus the one pending, so the cap is hit on the accepting edge.
   assign term   = accept && (req_last || (enc_ok && (issued + 1'b1 == MAXW)));
   assign busy   = (state == S_LOAD) || (state == S_DRAIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         req_ready <= 1'b0;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         count     <= '0;
         issued    <= '0;
         next_addr <= BASE;
      end else begin
         im_we <= 1'b0;
         if (im_we) count <= count + 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  req_ready <= 1'b1;
                  count     <= '0;
                  err       <= 1'b0;
                  issued    <= '0;
                  next_addr <= BASE;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (enc_ok) begin
                     im_we     <= 1'b1;
                     im_addr   <= next_addr;
                     im_wdata  <= enc_word;
                     next_addr <= next_addr + 1'b1;
                     issued    <= issued + 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
                  if (term) begin
                     req_ready <= 1'b0;
                     state     <= S_DRAIN;
                  end
               end
            end
            // Any pending write is on the bus during this cycle and retires at its end.
            S_DRAIN: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
